multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Parametrised multicycle successor of the single-cycle ARM control decoder.
- Sequences each instruction through a Moore FSM: fetch, decode, execute, memory, writeback.
- Owns the NZCV flag register and conditional-execution check.
- Adds EOR/CMP, byte load/store and a memory-ready handshake. Sits between the instruction register and the shared datapath/memory.

Parameters:
- ALUCTRL_W, 3, width of ALUControl; must be >=3. Upper bits are zero.
- BYTE_EN, 1, when 1 LDRB/STRB assert MemByte; when 0 MemByte is tied 0.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- Cond  in  4  instruction bits [31:28]
- Op  in  2  instruction bits [27:26]
- Funct  in  6  instruction bits [25:20]
- Rd  in  4  instruction bits [15:12]
- ALUFlags  in  4  NZCV from ALU
- mem_ready  in  1  memory access completes this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  0=PC, 1=ALU result register as memory address
- IRWrite  out  1  instruction register enable
- MemWrite  out  1  memory write strobe
- MemByte  out  1  byte access
- RegWrite  out  1  register file write
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  1  0=RD1, 1=PC
- ALUSrcB  out  2  00=RD2, 01=ExtImm, 10=constant 4
- ImmSrc  out  2  immediate format
- RegSrc  out  2  register read address select
- Reverse  out  1  swap ALU operands (RSB)
- ALUControl  out  ALUCTRL_W  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR
- Flags  out  4  current NZCV
- illegal  out  1  sticky: unimplemented Op/Funct decoded

Behaviour:
- Reset (rst_n low, async): state=FETCH, Flags=0, cond_ex=0, illegal=0. All strobes (PCWrite, IRWrite, MemWrite, RegWrite) forced 0. Muxes hold FETCH values. First active cycle after release is FETCH.
- FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10. IRWrite=PCWrite=mem_ready. Stay while !mem_ready; else go to DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10. Latch cond_ex from Cond and Flags (EQ,NE,CS,CC,MI,PL,VS,VC,HI,LS,GE,LT,GT,LE,AL; 1111 gives 0). Next state:
  - Op=01 -> MEMADR
  - Op=00 with Funct[5] -> EXECI
  - Op=00 without Funct[5] -> EXECR
  - Op=10 -> BRANCH
  - Op=11 -> FETCH, set illegal
- MEMADR: ALUSrcA=0, ALUSrcB=01, ADD. If Funct[0] -> MEMREAD, else MEMWRITE.
- MEMREAD: AdrSrc=1. Hold until mem_ready, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=cond_ex -> FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=cond_ex. Hold until mem_ready, then FETCH. MemWrite stays asserted while waiting.
- MemByte=Funct[2]&BYTE_EN in MEMADR, MEMREAD, MEMWB and MEMWRITE.
- EXECR/EXECI: ALUSrcB=00/01, ALUSrcA=0. Funct[4:1] decode:
  - 0100 ADD; 0010 SUB; 0011 SUB+Reverse; 0000 AND; 1100 ORR; 0001 EOR; 1010 CMP (SUB, no writeback).
  - Other codes: ALUControl=ADD, set illegal, suppress writeback.
  - Flags update at end of this state if Funct[0] & cond_ex: NZ always, CV only for ADD/SUB/RSB/CMP. CMP forces the flag update regardless of Funct[0].
  - Next state: ALUWB.
- ALUWB: ResultSrc=00. RegWrite=cond_ex & !CMP & !illegal-op. If Rd=1111 and write, also PCWrite=1. -> FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=cond_ex -> FETCH.
- ImmSrc/RegSrc follow Op: DP=00/00, MEM=01/10 (STR reads Rd), B=10/x1.
- Latency: DP 4 cycles, LDR 5, STR 4, B 3. Each mem_ready-low cycle adds one.
- Flags change only via the DP flag update; a condition failure never alters Flags.

Optional Feature:
- Macro PERF_CNT_EN.
- When defined: adds 32-bit outputs cycle_cnt (increments every cycle after reset) and instr_cnt (increments on each transition into FETCH from a final state). Both wrap at 2^32 and reset to 0.
- When undefined: no ports, no counters.

Decomposition:
- Package ctrl_pkg holds:
  - state_t enum (FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH)
  - ALU op localparams
  - cond code constants
- One sub-module cond_unit: Flags register, condition evaluation, gated flag write.

Test Plan:
- ADDS R1,R2,#0 with R2 giving result 0 (Op=00, Funct=101001) -> 4 cycles. Z=1 after EXECI. RegWrite=1 in ALUWB, ALUControl=000.
- CMP with ALUFlags=0100, then ADDNE (Cond=0001) -> NE fails. RegWrite stays 0 in ALUWB; Flags remain 0100.
- LDR with mem_ready low 2 cycles in MEMREAD -> state holds 2 extra cycles. RegWrite=1 in MEMWB, total 7 cycles.
- STRB, BYTE_EN=1 (Funct=000100) -> MemWrite=1 and MemByte=1 in MEMWRITE; RegWrite never 1.
- B with Cond=1110 -> PCWrite=1 in BRANCH, 3 cycles. Op=11 -> illegal=1 and returns to FETCH.
- rst_n asserted mid-MEMWRITE -> MemWrite drops to 0 immediately; state FETCH and Flags=0 on release.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM control unit:
// FSM states, ALU operation codes, DP command codes and condition codes.
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_EOR = 3'b100;

    // Funct[4:1] command field of data-processing instructions
    localparam logic [3:0] DP_AND = 4'b0000;
    localparam logic [3:0] DP_EOR = 4'b0001;
    localparam logic [3:0] DP_SUB = 4'b0010;
    localparam logic [3:0] DP_RSB = 4'b0011;
    localparam logic [3:0] DP_ADD = 4'b0100;
    localparam logic [3:0] DP_CMP = 4'b1010;
    localparam logic [3:0] DP_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;

endpackage

// File: rtl/multicycle_ctrl_cond_unit.sv
// NZCV flag register, condition evaluation latched as cond_ex, and
// flag writes gated by the latched condition result.
module cond_unit
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic       cond_latch,
    input  logic       flag_upd_nz,
    input  logic       flag_upd_cv,
    output logic [3:0] Flags,
    output logic       cond_ex
);
    logic n, z, c, v;
    logic pass;

    assign {n, z, c, v} = Flags;

    always_comb begin
        pass = 1'b0;
        case (Cond)
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = ~(n ^ v);
            COND_LT: pass = n ^ v;
            COND_GT: pass = ~z & ~(n ^ v);
            COND_LE: pass = z | (n ^ v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Flags   <= 4'b0000;
            cond_ex <= 1'b0;
        end else begin
            if (cond_latch)
                cond_ex <= pass;
            if (flag_upd_nz && cond_ex)
                Flags[3:2] <= ALUFlags[3:2];
            if (flag_upd_cv && cond_ex)
                Flags[1:0] <= ALUFlags[1:0];
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle ARM control FSM: fetch/decode/execute/memory/writeback sequencing.
// Optional PERF_CNT_EN adds cycle_cnt/instr_cnt performance counters.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 3,
    parameter int BYTE_EN   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           Cond,
    input  logic [1:0]           Op,
    input  logic [5:0]           Funct,
    input  logic [3:0]           Rd,
    input  logic [3:0]           ALUFlags,
    input  logic                 mem_ready,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 IRWrite,
    output logic                 MemWrite,
    output logic                 MemByte,
    output logic                 RegWrite,
    output logic [1:0]           ResultSrc,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ImmSrc,
    output logic [1:0]           RegSrc,
    output logic                 Reverse,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic [3:0]           Flags,
    output logic                 illegal
`ifdef PERF_CNT_EN
    ,
    output logic [31:0]          cycle_cnt,
    output logic [31:0]          instr_cnt
`endif
);
    state_t     state, state_nxt;
    logic       cond_ex, cond_latch, flag_upd_nz, flag_upd_cv, set_illegal;
    logic       pc_w, ir_w, mem_w, reg_w, mem_phase;
    logic [2:0] alu_op, dp_alu;
    logic       dp_rev, dp_cmp, dp_bad, dp_arith;

    cond_unit u_cond (
        .clk        (clk),
        .rst_n      (rst_n),
        .Cond       (Cond),
        .ALUFlags   (ALUFlags),
        .cond_latch (cond_latch),
        .flag_upd_nz(flag_upd_nz),
        .flag_upd_cv(flag_upd_cv),
        .Flags      (Flags),
        .cond_ex    (cond_ex)
    );

    always_comb begin
        dp_alu   = ALU_ADD;
        dp_rev   = 1'b0;
        dp_cmp   = 1'b0;
        dp_bad   = 1'b0;
        dp_arith = 1'b0;
        case (Funct[4:1])
            DP_ADD: dp_arith = 1'b1;
            DP_SUB: begin dp_alu = ALU_SUB; dp_arith = 1'b1; end
            DP_RSB: begin dp_alu = ALU_SUB; dp_arith = 1'b1; dp_rev = 1'b1; end
            DP_AND: dp_alu = ALU_AND;
            DP_ORR: dp_alu = ALU_ORR;
            DP_EOR: dp_alu = ALU_EOR;
            DP_CMP: begin dp_alu = ALU_SUB; dp_arith = 1'b1; dp_cmp = 1'b1; end
            default: dp_bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= FETCH;
        else
            state <= state_nxt;
    end

    // Mux defaults are the FETCH settings so reset also presents them.
    always_comb begin
        state_nxt   = state;
        pc_w        = 1'b0;
        ir_w        = 1'b0;
        mem_w       = 1'b0;
        reg_w       = 1'b0;
        mem_phase   = 1'b0;
        cond_latch  = 1'b0;
        flag_upd_nz = 1'b0;
        flag_upd_cv = 1'b0;
        set_illegal = 1'b0;
        AdrSrc      = 1'b0;
        ALUSrcA     = 1'b1;
        ALUSrcB     = 2'b10;
        ResultSrc   = 2'b10;
        alu_op      = ALU_ADD;
        Reverse     = 1'b0;
        case (state)
            FETCH: begin
                ir_w = mem_ready;
                pc_w = mem_ready;
                if (mem_ready)
                    state_nxt = DECODE;
            end
            DECODE: begin
                cond_latch = 1'b1;
                case (Op)
                    2'b01:   state_nxt = MEMADR;
                    2'b00:   state_nxt = Funct[5] ? EXECI : EXECR;
                    2'b10:   state_nxt = BRANCH;
                    default: begin
                        state_nxt   = FETCH;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA   = 1'b0;
                ALUSrcB   = 2'b01;
                mem_phase = 1'b1;
                state_nxt = Funct[0] ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                AdrSrc    = 1'b1;
                mem_phase = 1'b1;
                if (mem_ready)
                    state_nxt = MEMWB;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                reg_w     = cond_ex;
                mem_phase = 1'b1;
                state_nxt = FETCH;
            end
            MEMWRITE: begin
                AdrSrc    = 1'b1;
                mem_w     = cond_ex;
                mem_phase = 1'b1;
                if (mem_ready)
                    state_nxt = FETCH;
            end
            EXECR, EXECI: begin
                ALUSrcA     = 1'b0;
                ALUSrcB     = (state == EXECI) ? 2'b01 : 2'b00;
                alu_op      = dp_alu;
                Reverse     = dp_rev;
                flag_upd_nz = ~dp_bad & (Funct[0] | dp_cmp);
                flag_upd_cv = ~dp_bad & (Funct[0] | dp_cmp) & dp_arith;
                set_illegal = dp_bad;
                state_nxt   = ALUWB;
            end
            ALUWB: begin
                ResultSrc = 2'b00;
                reg_w     = cond_ex & ~dp_cmp & ~dp_bad;
                pc_w      = cond_ex & ~dp_cmp & ~dp_bad & (Rd == 4'hF);
                state_nxt = FETCH;
            end
            BRANCH: begin
                ALUSrcA   = 1'b0;
                ALUSrcB   = 2'b01;
                pc_w      = cond_ex;
                state_nxt = FETCH;
            end
            default: state_nxt = FETCH;
        endcase
    end

    always_comb begin
        ImmSrc = 2'b00;
        RegSrc = 2'b00;
        case (Op)
            2'b01:   begin ImmSrc = 2'b01; RegSrc = 2'b10; end
            2'b10:   begin ImmSrc = 2'b10; RegSrc = 2'b01; end
            default: begin ImmSrc = 2'b00; RegSrc = 2'b00; end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            illegal <= 1'b0;
        else if (set_illegal)
            illegal <= 1'b1;
    end

    // Strobes are gated by rst_n so they drop the moment reset asserts.
    assign PCWrite    = pc_w  & rst_n;
    assign IRWrite    = ir_w  & rst_n;
    assign MemWrite   = mem_w & rst_n;
    assign RegWrite   = reg_w & rst_n;
    assign MemByte    = mem_phase & Funct[2] & (BYTE_EN != 0);
    assign ALUControl = ALUCTRL_W'(alu_op);

`ifdef PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= 32'd0;
            instr_cnt <= 32'd0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (state != FETCH && state_nxt == FETCH)
                instr_cnt <= instr_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed vector table, reset
// corner case, then random instruction stream against an instruction-level model.
module tb_multicycle_ctrl;

    logic       clk;
    logic       rst_n;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] ALUFlags;
    logic       mem_ready;
    logic       PCWrite, AdrSrc, IRWrite, MemWrite, MemByte, RegWrite;
    logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc;
    logic       ALUSrcA, Reverse;
    logic [2:0] ALUControl;
    logic [3:0] Flags;
    logic       illegal;
`ifdef PERF_CNT_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    multicycle_ctrl #(.ALUCTRL_W(3), .BYTE_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
        .ALUFlags(ALUFlags), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .IRWrite(IRWrite), .MemWrite(MemWrite), .MemByte(MemByte), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .RegSrc(RegSrc), .Reverse(Reverse), .ALUControl(ALUControl), .Flags(Flags),
        .illegal(illegal)
`ifdef PERF_CNT_EN
        , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] cond;
        logic [1:0] op;
        logic [5:0] funct;
        logic [3:0] rd;
        logic [3:0] af;
        int         wf;
        int         wm;
    } instr_t;

    typedef struct {
        int n;
        int regw;
        int memw;
        int pcw;
        int memb;
        int alu;
        int rev;
        int flags;
        int ill;
    } exp_t;

    typedef struct {
        instr_t i;
        exp_t   e;
    } vec_t;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Runs one instruction window of n cycles starting in FETCH. mem_ready is
    // low for wf fetch cycles and for wm cycles of the memory access phase.
    task automatic run(input instr_t in, input int n, output exp_t o,
                       output int irw_cnt, output int irw_pos);
        o = '{default: 0};
        irw_cnt = 0;
        irw_pos = -1;
        Cond = in.cond; Op = in.op; Funct = in.funct; Rd = in.rd; ALUFlags = in.af;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            mem_ready = !((k < in.wf) || (k >= in.wf + 3 && k < in.wf + 3 + in.wm));
            #1;
            if (IRWrite) begin irw_cnt++; irw_pos = k; end
            o.regw += int'(RegWrite);
            o.memw += int'(MemWrite);
            o.pcw  += int'(PCWrite);
            o.memb += int'(MemByte);
            if (k == in.wf + 2) begin
                o.alu = int'(ALUControl);
                o.rev = int'(Reverse);
            end
        end
        @(posedge clk);
        #1;
        o.flags = int'(Flags);
        o.ill   = int'(illegal);
    endtask

    task automatic run_and_compare(input string tag, input instr_t in, input exp_t e);
        exp_t o;
        int   ic, ip;
        run(in, e.n, o, ic, ip);
        chk({tag, " fetch_cnt"}, ic, 1);
        chk({tag, " fetch_pos"}, ip, in.wf);
        chk({tag, " regwrite"},  o.regw, e.regw);
        chk({tag, " memwrite"},  o.memw, e.memw);
        chk({tag, " pcwrite"},   o.pcw,  e.pcw);
        chk({tag, " membyte"},   o.memb, e.memb);
        chk({tag, " aluctl"},    o.alu,  e.alu);
        chk({tag, " reverse"},   o.rev,  e.rev);
        chk({tag, " flags"},     o.flags, e.flags);
        chk({tag, " illegal"},   o.ill,  e.ill);
    endtask

    function automatic bit cond_true(input logic [3:0] c, input logic [3:0] f);
        bit n_f, z_f, c_f, v_f;
        {n_f, z_f, c_f, v_f} = f;
        case (c)
            4'h0: return z_f;
            4'h1: return !z_f;
            4'h2: return c_f;
            4'h3: return !c_f;
            4'h4: return n_f;
            4'h5: return !n_f;
            4'h6: return v_f;
            4'h7: return !v_f;
            4'h8: return c_f && !z_f;
            4'h9: return !c_f || z_f;
            4'hA: return n_f == v_f;
            4'hB: return n_f != v_f;
            4'hC: return !z_f && (n_f == v_f);
            4'hD: return z_f || (n_f != v_f);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    vec_t vt[13];
    logic [3:0] legal_cmd[7];
    logic [3:0] mflags;
    int         mill;
    bit         seen;

    initial begin
        // cond, op, funct, rd, aluflags, wf, wm  |  n, regw, memw, pcw, memb, alu, rev, flags, ill
        vt[0]  = '{'{4'hE, 2'd0, 6'b101001, 4'd1,  4'b0100, 0, 0}, '{4, 1, 0, 1, 0, 0, 0, 4'b0100, 0}};
        vt[1]  = '{'{4'hE, 2'd0, 6'b000011, 4'd15, 4'b1011, 2, 0}, '{6, 1, 0, 2, 0, 4, 0, 4'b1000, 0}};
        vt[2]  = '{'{4'hE, 2'd0, 6'b010100, 4'd0,  4'b0100, 0, 0}, '{4, 0, 0, 1, 0, 1, 0, 4'b0100, 0}};
        vt[3]  = '{'{4'h1, 2'd0, 6'b001000, 4'd3,  4'b0000, 0, 0}, '{4, 0, 0, 1, 0, 0, 0, 4'b0100, 0}};
        vt[4]  = '{'{4'hE, 2'd0, 6'b100111, 4'd2,  4'b0011, 0, 0}, '{4, 1, 0, 1, 0, 1, 1, 4'b0011, 0}};
        vt[5]  = '{'{4'hE, 2'd1, 6'b011001, 4'd4,  4'b0000, 0, 2}, '{7, 1, 0, 1, 0, 0, 0, 4'b0011, 0}};
        vt[6]  = '{'{4'hE, 2'd1, 6'b000100, 4'd5,  4'b0000, 0, 1}, '{5, 0, 2, 1, 3, 0, 0, 4'b0011, 0}};
        vt[7]  = '{'{4'h0, 2'd1, 6'b000000, 4'd5,  4'b0000, 0, 1}, '{5, 0, 0, 1, 0, 0, 0, 4'b0011, 0}};
        vt[8]  = '{'{4'hE, 2'd2, 6'b000000, 4'd0,  4'b0000, 0, 0}, '{3, 0, 0, 2, 0, 0, 0, 4'b0011, 0}};
        vt[9]  = '{'{4'h0, 2'd2, 6'b000000, 4'd0,  4'b0000, 1, 0}, '{4, 0, 0, 1, 0, 0, 0, 4'b0011, 0}};
        vt[10] = '{'{4'hF, 2'd0, 6'b001000, 4'd6,  4'b1111, 0, 0}, '{4, 0, 0, 1, 0, 0, 0, 4'b0011, 0}};
        vt[11] = '{'{4'hE, 2'd0, 6'b001110, 4'd7,  4'b1111, 0, 0}, '{4, 0, 0, 1, 0, 0, 0, 4'b0011, 1}};
        vt[12] = '{'{4'hE, 2'd3, 6'b000000, 4'd0,  4'b0000, 0, 0}, '{2, 0, 0, 1, 0, 0, 0, 4'b0011, 1}};
        legal_cmd = '{4'b0100, 4'b0010, 4'b0011, 4'b0000, 4'b1100, 4'b0001, 4'b1010};

        rst_n = 1'b0; mem_ready = 1'b1;
        Cond = 4'hE; Op = 2'd0; Funct = 6'd0; Rd = 4'd0; ALUFlags = 4'd0;
        #12;
        chk("reset irwrite",  int'(IRWrite), 0);
        chk("reset pcwrite",  int'(PCWrite), 0);
        chk("reset memwrite", int'(MemWrite), 0);
        chk("reset regwrite", int'(RegWrite), 0);
        chk("reset alusrcb",  int'(ALUSrcB), 2);
        chk("reset flags",    int'(Flags), 0);
        chk("reset illegal",  int'(illegal), 0);
        mem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++)
            run_and_compare($sformatf("vec%0d", i), vt[i].i, vt[i].e);

        // Reset while a store waits on memory: MemWrite must drop at once.
        Cond = 4'hE; Op = 2'd1; Funct = 6'b000000; Rd = 4'd1;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            mem_ready = (k == 0);
            #1;
            if (k == 0) chk("fetch after op11", int'(IRWrite), 1);
            if (MemWrite) seen = 1'b1;
        end
        chk("memwrite reached", int'(seen), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst memwrite", int'(MemWrite), 0);
        chk("rst flags",    int'(Flags), 0);
        chk("rst illegal",  int'(illegal), 0);
        @(negedge clk);
        mem_ready = 1'b0;
        rst_n = 1'b1;
        Op = 2'd2;
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        chk("fetch after reset", int'(IRWrite), 1);
        repeat (3) @(posedge clk);
        #1;

        mflags = 4'b0000;
        mill = 0;
        for (int t = 0; t < 150; t++) begin
            instr_t in;
            exp_t   e;
            int     sel;
            bit     pass;
            sel = $urandom_range(0, 9);
            in.cond  = 4'($urandom_range(0, 15));
            in.af    = 4'($urandom_range(0, 15));
            in.rd    = 4'($urandom_range(0, 15));
            in.funct = 6'($urandom_range(0, 63));
            in.wf    = $urandom_range(0, 2);
            in.wm    = $urandom_range(0, 3);
            in.op    = (sel < 5) ? 2'd0 : (sel < 8) ? 2'd1 : (sel == 8) ? 2'd2 : 2'd3;
            if (in.op == 2'd0) in.funct[4:1] = legal_cmd[$urandom_range(0, 6)];
            e = '{default: 0};
            pass = cond_true(in.cond, mflags);
            e.pcw = 1;
            case (in.op)
                2'd0: begin
                    bit is_cmp, arith, wr;
                    is_cmp = (in.funct[4:1] == 4'b1010);
                    arith  = is_cmp || in.funct[4:1] inside {4'b0100, 4'b0010, 4'b0011};
                    case (in.funct[4:1])
                        4'b0010, 4'b0011, 4'b1010: e.alu = 1;
                        4'b0000: e.alu = 2;
                        4'b1100: e.alu = 3;
                        4'b0001: e.alu = 4;
                        default: e.alu = 0;
                    endcase
                    e.rev = (in.funct[4:1] == 4'b0011) ? 1 : 0;
                    if (pass && (in.funct[0] || is_cmp)) begin
                        mflags[3:2] = in.af[3:2];
                        if (arith) mflags[1:0] = in.af[1:0];
                    end
                    wr = pass && !is_cmp;
                    e.regw = wr ? 1 : 0;
                    e.pcw  = (wr && in.rd == 4'hF) ? 2 : 1;
                    e.n    = in.wf + 4;
                end
                2'd1: begin
                    if (in.funct[0]) begin
                        e.regw = pass ? 1 : 0;
                        e.memb = in.funct[2] ? in.wm + 3 : 0;
                        e.n    = in.wf + 5 + in.wm;
                    end else begin
                        e.memw = pass ? in.wm + 1 : 0;
                        e.memb = in.funct[2] ? in.wm + 2 : 0;
                        e.n    = in.wf + 4 + in.wm;
                    end
                end
                2'd2: begin
                    e.pcw = pass ? 2 : 1;
                    e.n   = in.wf + 3;
                end
                default: begin
                    mill = 1;
                    e.n  = in.wf + 2;
                end
            endcase
            e.flags = int'(mflags);
            e.ill   = mill;
            run_and_compare($sformatf("rnd%0d", t), in, e);
        end

        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        chk("final fetch", int'(IRWrite), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
